// File: rtl/csa3_reg_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared constants for the csa3_reg carry-save adder slice.
//   CSA_WIDTH : default operand width used by the interface and the top.
// -----------------------------------------------------------------------------
package csa_pkg;
   localparam int CSA_WIDTH = 8;
endpackage

// File: rtl/csa3_reg_if.sv
// -----------------------------------------------------------------------------
// csa3_reg_if
// Operand/result bundle for csa3_reg.
//   in_valid, in_x, in_y, in_z : operand triple and its valid strobe
//   out_valid                  : registered result strobe
//   carry                      : carry vector, bit i weighs 2^(i+1)
//   sum                        : sum vector, bit i weighs 2^i
//   total                      : resolved x+y+z, WIDTH+2 bits
// Modports: master drives operands, slave (the adder) drives results.
// -----------------------------------------------------------------------------
interface csa3_reg_if
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic [WIDTH-1:0] in_z;
   logic             out_valid;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum;
   logic [WIDTH+1:0] total;

   modport master (
      output in_valid, in_x, in_y, in_z,
      input  out_valid, carry, sum, total
   );

   modport slave (
      input  in_valid, in_x, in_y, in_z,
      output out_valid, carry, sum, total
   );
endinterface

// File: rtl/csa3_reg_cells.sv
// -----------------------------------------------------------------------------
// half_adder / full_adder
// Purely combinational one-bit adder cells shared by the CSA row and the
// ripple carry-propagate chain of csa3_reg.
//   half_adder: a, b       -> sum = a^b,     cout = a&b
//   full_adder: a, b, cin  -> sum = a^b^cin, cout = majority(a,b,cin)
// -----------------------------------------------------------------------------
module half_adder (
   output logic cout,
   output logic sum,
   input  logic a,
   input  logic b
);
   assign sum  = a ^ b;
   assign cout = a & b;
endmodule

module full_adder (
   output logic cout,
   output logic sum,
   input  logic a,
   input  logic b,
   input  logic cin
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/csa3_reg.sv
// -----------------------------------------------------------------------------
// csa3_reg
// Registered 3:2 compressor. Reduces three unsigned WIDTH-bit operands to a
// sum/carry pair in redundant form and also resolves them into the full
// binary total through a ripple chain. One-cycle latency, no back-pressure.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : csa3_reg_if slave (operands in, registered results out)
// -----------------------------------------------------------------------------
module csa3_reg
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   csa3_reg_if.slave  bus
);
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH+1:0] w_total;
   // w_rc[i] is the ripple carry out of total bit i.
   logic [WIDTH:1]   w_rc;

   logic             r_vld_p1;
   logic [WIDTH-1:0] r_sum_p1;
   logic [WIDTH-1:0] r_carry_p1;
   logic [WIDTH+1:0] r_total_p1;

   genvar i;

   // CSA row: one full adder per bit compresses x, y, z.
   for (i = 0; i < WIDTH; i++) begin : g_csa
      full_adder u_fa (
         .cout (w_carry[i]),
         .sum  (w_sum[i]),
         .a    (bus.in_x[i]),
         .b    (bus.in_y[i]),
         .cin  (bus.in_z[i])
      );
   end

   // Ripple stage: carry[i-1] lines up with sum[i] because carry is unshifted.
   assign w_total[0] = w_sum[0];

   for (i = 1; i <= WIDTH; i++) begin : g_rip
      if (i == 1) begin : g_lo
         half_adder u_ha (
            .cout (w_rc[i]),
            .sum  (w_total[i]),
            .a    (w_sum[i]),
            .b    (w_carry[i-1])
         );
      end else if (i < WIDTH) begin : g_mid
         full_adder u_fa (
            .cout (w_rc[i]),
            .sum  (w_total[i]),
            .a    (w_sum[i]),
            .b    (w_carry[i-1]),
            .cin  (w_rc[i-1])
         );
      end else begin : g_hi
         // No sum bit exists at weight 2^WIDTH; only the top carry enters.
         half_adder u_ha (
            .cout (w_rc[i]),
            .sum  (w_total[i]),
            .a    (w_carry[i-1]),
            .b    (w_rc[i-1])
         );
      end
   end

   assign w_total[WIDTH+1] = w_rc[WIDTH];

   // ---- stage p0 -> p1: output registers ----
   // Data regs only load on in_valid so results hold through idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1   <= 1'b0;
         r_sum_p1   <= '0;
         r_carry_p1 <= '0;
         r_total_p1 <= '0;
      end else begin
         r_vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_sum_p1   <= w_sum;
            r_carry_p1 <= w_carry;
            r_total_p1 <= w_total;
         end
      end
   end

   assign bus.out_valid = r_vld_p1;
   assign bus.sum       = r_sum_p1;
   assign bus.carry     = r_carry_p1;
   assign bus.total     = r_total_p1;
endmodule

// File: tb/tb_csa3_reg.sv
// -----------------------------------------------------------------------------
// tb_csa3_reg
// Drives three csa3_reg instances (WIDTH = 8, 4, 16) and exhaustively the two
// adder cells. Expected results come from a bit-counting reference model:
// for each bit position the number of ones among x, y, z gives the sum bit
// (count mod 2) and the carry bit (count / 2); total is plain x + y + z.
// -----------------------------------------------------------------------------
module tb_csa3_reg;
   localparam int NW = 3;
   localparam int WID [NW] = '{8, 4, 16};
   localparam int N_RAND = 10000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   csa3_reg_if #(.WIDTH(8))  if8  ();
   csa3_reg_if #(.WIDTH(4))  if4  ();
   csa3_reg_if #(.WIDTH(16)) if16 ();

   csa3_reg #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   csa3_reg #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
   csa3_reg #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   logic ha_a, ha_b, ha_c, ha_s;
   logic fa_a, fa_b, fa_ci, fa_c, fa_s;

   half_adder u_ha (.cout(ha_c), .sum(ha_s), .a(ha_a), .b(ha_b));
   full_adder u_fa (.cout(fa_c), .sum(fa_s), .a(fa_a), .b(fa_b), .cin(fa_ci));

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what each DUT's outputs should show after the next edge.
   longint unsigned m_s [NW];
   longint unsigned m_c [NW];
   longint unsigned m_t [NW];
   bit              m_v [NW];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned msk(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NW; k++) begin
         m_s[k] = 0; m_c[k] = 0; m_t[k] = 0; m_v[k] = 1'b0;
      end
   endtask

   // Put an operand triple on DUT k and advance its reference model.
   task automatic drive(input int k, input bit v, input longint unsigned xi,
                        input longint unsigned yi, input longint unsigned zi);
      longint unsigned x, y, z;
      int cnt;
      x = xi & msk(WID[k]);
      y = yi & msk(WID[k]);
      z = zi & msk(WID[k]);
      case (k)
         0: begin if8.in_valid = v;  if8.in_x = x[7:0];   if8.in_y = y[7:0];   if8.in_z = z[7:0];   end
         1: begin if4.in_valid = v;  if4.in_x = x[3:0];   if4.in_y = y[3:0];   if4.in_z = z[3:0];   end
         default: begin if16.in_valid = v; if16.in_x = x[15:0]; if16.in_y = y[15:0]; if16.in_z = z[15:0]; end
      endcase
      if (rst_n) begin
         m_v[k] = v;
         if (v) begin
            m_s[k] = 0;
            m_c[k] = 0;
            for (int i = 0; i < WID[k]; i++) begin
               cnt = int'((x >> i) & 1) + int'((y >> i) & 1) + int'((z >> i) & 1);
               m_s[k] |= longint'(cnt % 2) << i;
               m_c[k] |= longint'(cnt / 2) << i;
            end
            m_t[k] = x + y + z;
         end
      end
   endtask

   task automatic check_dut(input int k);
      logic [63:0] gs, gc, gt, gv;
      string p;
      case (k)
         0: begin gs = 64'(if8.sum);  gc = 64'(if8.carry);  gt = 64'(if8.total);  gv = 64'(if8.out_valid);  end
         1: begin gs = 64'(if4.sum);  gc = 64'(if4.carry);  gt = 64'(if4.total);  gv = 64'(if4.out_valid);  end
         default: begin gs = 64'(if16.sum); gc = 64'(if16.carry); gt = 64'(if16.total); gv = 64'(if16.out_valid); end
      endcase
      p = $sformatf("w%0d", WID[k]);
      chk({p, " sum"},       gs, m_s[k]);
      chk({p, " carry"},     gc, m_c[k]);
      chk({p, " total"},     gt, m_t[k]);
      chk({p, " out_valid"}, gv, 64'(m_v[k]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < NW; k++) check_dut(k);
   endtask

   // Fixed expectations for the 8-bit instance in the directed cases.
   task automatic chk8(input string tag, input logic [7:0] c, input logic [7:0] s,
                       input logic [9:0] t, input logic v);
      chk({tag, " carry"},     64'(if8.carry),     64'(c));
      chk({tag, " sum"},       64'(if8.sum),       64'(s));
      chk({tag, " total"},     64'(if8.total),     64'(t));
      chk({tag, " out_valid"}, 64'(if8.out_valid), 64'(v));
   endtask

   task automatic idle_others();
      drive(1, 1'b0, 0, 0, 0);
      drive(2, 1'b0, 0, 0, 0);
   endtask

   initial begin
      model_clear();
      for (int k = 0; k < NW; k++) drive(k, 1'b0, 0, 0, 0);

      // Adder cells, every input combination.
      for (int v = 0; v < 4; v++) begin
         ha_a = v[1]; ha_b = v[0];
         #1;
         chk($sformatf("ha %0d%0d", v[1], v[0]), {62'd0, ha_c, ha_s}, 64'(v[1] + v[0]));
      end
      for (int v = 0; v < 8; v++) begin
         fa_a = v[2]; fa_b = v[1]; fa_ci = v[0];
         #1;
         chk($sformatf("fa %0d%0d%0d", v[2], v[1], v[0]), {62'd0, fa_c, fa_s},
             64'(v[2] + v[1] + v[0]));
      end

      // Held in reset with valid traffic: nothing may be captured.
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < NW; k++) drive(k, 1'b1, $urandom, $urandom, $urandom);
         tick();
      end
      rst_n = 1'b1;

      // Directed cases on the 8-bit instance, including an idle gap.
      drive(0, 1'b1, 'h01, 'h02, 'h04); idle_others(); tick();
      chk8("dir 01/02/04", 8'h00, 8'h07, 10'd7, 1'b1);
      drive(0, 1'b0, 'hAA, 'hBB, 'hCC); idle_others(); tick();
      chk8("dir idle hold", 8'h00, 8'h07, 10'd7, 1'b0);
      drive(0, 1'b1, 'h55, 'h33, 'h0F); idle_others(); tick();
      chk8("dir 55/33/0F", 8'h17, 8'h69, 10'd151, 1'b1);
      drive(0, 1'b1, 'hFF, 'hFF, 'hFF); idle_others(); tick();
      chk8("dir FF/FF/FF", 8'hFF, 8'hFF, 10'b1011111101, 1'b1);

      // Width extremes on the other instances.
      drive(0, 1'b0, 0, 0, 0);
      drive(1, 1'b1, 'hF, 'hF, 'hF);
      drive(2, 1'b1, 'hFFFF, 'hFFFF, 'hFFFF);
      tick();

      // Random stream on all widths, with one asynchronous reset mid-stream.
      for (int c = 0; c < N_RAND; c++) begin
         for (int k = 0; k < NW; k++)
            drive(k, $urandom_range(0, 7) != 0, $urandom, $urandom, $urandom);
         tick();
         if (c == N_RAND / 2) begin
            rst_n = 1'b0;
            #1;
            model_clear();
            for (int k = 0; k < NW; k++) check_dut(k);
            #1;
            rst_n = 1'b1;
            for (int k = 0; k < NW; k++) drive(k, 1'b1, $urandom, $urandom, $urandom);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
